// File: rtl/alu_pkg.sv
// Shared opcodes, multiply/divide FSM encoding and decode helper for alu_pipe_md.
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_NOR   = 4'h4;
    localparam logic [3:0] OP_RSVD  = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_SLT   = 4'h7;
    localparam logic [3:0] OP_SLTU  = 4'h8;
    localparam logic [3:0] OP_SLL   = 4'h9;
    localparam logic [3:0] OP_SRL   = 4'hA;
    localparam logic [3:0] OP_SRA   = 4'hB;
    localparam logic [3:0] OP_MULTU = 4'hC;
    localparam logic [3:0] OP_DIVU  = 4'hD;
    localparam logic [3:0] OP_MFHI  = 4'hE;
    localparam logic [3:0] OP_MFLO  = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// HI/LO are written only on the final iteration, so an aborted op leaves them intact.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             start,
    input  logic             op,       // 0 = MULTU, 1 = DIVU
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,     // final iteration completes at this clock edge
    output logic [WIDTH-1:0] lo_next,  // LO value being written when done=1
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] p_hi_q, p_lo_q, opnd_q;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH:0]   mul_sum, div_rem, div_diff;
    logic             last;

    assign busy    = (state_q != IDLE);
    assign last    = busy && (cnt_q == CNT_W'(1));
    assign done    = last && !flush;
    assign lo_next = step_lo;

    // One iteration: MUL keeps {acc, multiplier}; DIV keeps {remainder, dividend/quotient}.
    // A zero divisor always "subtracts", giving an all-ones quotient and remainder = A.
    always_comb begin
        step_hi  = p_hi_q;
        step_lo  = p_lo_q;
        mul_sum  = '0;
        div_rem  = '0;
        div_diff = '0;
        if (state_q == MUL) begin
            mul_sum = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, opnd_q} : '0);
            {step_hi, step_lo} = {mul_sum, p_lo_q[WIDTH-1:1]};
        end else if (state_q == DIV) begin
            div_rem  = {p_hi_q, p_lo_q[WIDTH-1]};
            div_diff = div_rem - {1'b0, opnd_q};
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {p_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_rem[WIDTH-1:0];
                step_lo = {p_lo_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Next-state: start from IDLE, return on last iteration or flush.
    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:     if (start && !flush) state_n = op ? DIV : MUL;
            MUL, DIV: if (flush || last)   state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // State, counter, partial registers and HI/LO update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            opnd_q  <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_n;
            if (flush) begin
                cnt_q <= '0;
            end else if (state_q == IDLE) begin
                if (start) begin
                    cnt_q  <= CNT_W'(WIDTH);
                    p_hi_q <= '0;
                    p_lo_q <= op ? a : b;
                    opnd_q <= op ? b : a;
                end
            end else begin
                cnt_q  <= cnt_q - CNT_W'(1);
                p_hi_q <= step_hi;
                p_lo_q <= step_lo;
                if (last) begin
                    hi <= step_hi;
                    lo <= step_lo;
                end
            end
        end
    end

endmodule

// File: rtl/alu_pipe_md.sv
// EX-stage ALU with registered result, valid/ready handshake and iterative MULTU/DIVU.
module alu_pipe_md
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       OpSel,
    output logic             out_valid,
    output logic [WIDTH-1:0] Res,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic               accept, start, md_busy, md_done;
    logic [WIDTH-1:0]   md_lo_next, alu_res;
    logic [SHAMT_W-1:0] shamt;

    assign in_ready = !md_busy;
    assign accept   = in_valid && in_ready;
    assign start    = accept && !flush && is_muldiv(OpSel);
    assign shamt    = B[SHAMT_W-1:0];

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_md (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .start   (start),
        .op      (OpSel == OP_DIVU),
        .a       (A),
        .b       (B),
        .busy    (md_busy),
        .done    (md_done),
        .lo_next (md_lo_next),
        .hi      (hi),
        .lo      (lo)
    );

    // Single-cycle ALU datapath.
    always_comb begin
        alu_res = '0;
        case (OpSel)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = A + B;
            OP_XOR:  alu_res = A ^ B;
            OP_NOR:  alu_res = ~(A | B);
            OP_SUB:  alu_res = A - B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  alu_res = A << shamt;
            OP_SRL:  alu_res = A >> shamt;
            OP_SRA:  alu_res = $signed(A) >>> shamt;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            default: alu_res = '0;
        endcase
    end

    // Output register: flush suppresses the pulse; Res/zero hold when nothing completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            Res       <= '0;
            zero      <= 1'b1;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (md_done) begin
            out_valid <= 1'b1;
            Res       <= md_lo_next;
            zero      <= (md_lo_next == '0);
        end else if (accept && !is_muldiv(OpSel)) begin
            out_valid <= 1'b1;
            Res       <= alu_res;
            zero      <= (alu_res == '0);
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_md.sv
// Directed/table-driven bench for alu_pipe_md (WIDTH=32).
module tb_alu_pipe_md;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid;
    logic        in_ready, out_valid, zero;
    logic [31:0] A, B, Res, hi, lo;
    logic [3:0]  OpSel;

    int checks   = 0;
    int failures = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    vec_t       vecs[20];
    logic [3:0] rops[14];

    alu_pipe_md #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .OpSel     (OpSel),
        .out_valid (out_valid),
        .Res       (Res),
        .zero      (zero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_SLL:  return a << s;
            OP_SRL:  return a >> s;
            OP_SRA:  return 32'($signed(a) >>> s);
            OP_MFHI: return m_hi;
            OP_MFLO: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    // Launch MULTU/DIVU, keep offering an ADD while busy, measure latency and stall length.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input string nm);
        int lat;
        int rdy0;
        in_valid = 1'b1; OpSel = op; A = a; B = b;
        tick();
        OpSel = OP_ADD; A = 32'd1; B = 32'd1;
        lat  = 1;
        rdy0 = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) rdy0++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check({nm, "_latency"}, lat, 33);
        check({nm, "_stall"}, rdy0, 32);
        check({nm, "_res"}, Res, exp_lo);
        check({nm, "_zero"}, zero, (exp_lo == 0));
        check({nm, "_hi"}, hi, exp_hi);
        check({nm, "_lo"}, lo, exp_lo);
        check({nm, "_ready"}, in_ready, 1);
        m_hi = exp_hi;
        m_lo = exp_lo;
    endtask

    initial begin
        vecs[0]  = '{OP_MFHI, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{OP_MFLO, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{OP_ADD,  32'hFFFFFFFF, 32'h1, 32'h0};
        vecs[3]  = '{OP_SUB,  32'd5, 32'd7, 32'hFFFFFFFE};
        vecs[4]  = '{OP_SLT,  32'hFFFFFFFF, 32'h1, 32'h1};
        vecs[5]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h1, 32'h0};
        vecs[6]  = '{OP_SRA,  32'h80000000, 32'd4, 32'hF8000000};
        vecs[7]  = '{OP_AND,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0};
        vecs[8]  = '{OP_OR,   32'h0F0F0000, 32'h000000FF, 32'h0F0F00FF};
        vecs[9]  = '{OP_XOR,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F};
        vecs[10] = '{OP_NOR,  32'hF0000000, 32'h0000000F, 32'h0FFFFFF0};
        vecs[11] = '{OP_SLL,  32'h1, 32'h1F, 32'h80000000};
        vecs[12] = '{OP_SLL,  32'h1, 32'h23, 32'h8};
        vecs[13] = '{OP_SRL,  32'h80000000, 32'd4, 32'h08000000};
        vecs[14] = '{OP_SLT,  32'h1, 32'hFFFFFFFF, 32'h0};
        vecs[15] = '{OP_SLTU, 32'h1, 32'hFFFFFFFF, 32'h1};
        vecs[16] = '{OP_RSVD, 32'h7B, 32'h5, 32'h0};
        vecs[17] = '{OP_SRA,  32'h7FFFFFF0, 32'd4, 32'h07FFFFFF};
        vecs[18] = '{OP_ADD,  32'h12345678, 32'h11111111, 32'h23456789};
        vecs[19] = '{OP_SUB,  32'h0, 32'h1, 32'hFFFFFFFF};
        rops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_NOR, OP_RSVD, OP_SUB,
                 OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MFHI, OP_MFLO};

        // Reset state
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; OpSel = '0; A = '0; B = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_res", Res, 0);
        check("rst_zero", zero, 1);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);

        // Table, one accept per cycle
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; OpSel = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            tick();
            check($sformatf("vec%0d_valid", i), out_valid, 1);
            check($sformatf("vec%0d_res", i), Res, vecs[i].res);
            check($sformatf("vec%0d_zero", i), zero, (vecs[i].res == 0));
            check($sformatf("vec%0d_ready", i), in_ready, 1);
        end

        // Idle cycle: no pulse, Res holds
        in_valid = 1'b0;
        tick();
        check("hold_valid", out_valid, 0);
        check("hold_res", Res, 32'hFFFFFFFF);

        // Accept in a flush cycle is discarded
        in_valid = 1'b1; OpSel = OP_ADD; A = 32'd2; B = 32'd3; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_idle_valid", out_valid, 0);
        check("flush_idle_res", Res, 32'hFFFFFFFF);

        // MULTU then MFHI in the completion cycle
        run_md(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu");
        in_valid = 1'b1; OpSel = OP_MFHI;
        tick();
        in_valid = 1'b0;
        check("mfhi_valid", out_valid, 1);
        check("mfhi_res", Res, 32'hFFFFFFFE);

        run_md(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu100_7");
        in_valid = 1'b1; OpSel = OP_MFLO;
        tick();
        in_valid = 1'b0;
        check("mflo_res", Res, 32'd14);

        run_md(OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, "divu9_0");

        // Random single-cycle ops, back-to-back
        for (int i = 0; i < 40; i++) begin
            logic [31:0] exp;
            in_valid = 1'b1;
            OpSel = rops[$urandom_range(0, 13)];
            A = $urandom;
            B = $urandom;
            exp = ref_alu(OpSel, A, B);
            tick();
            check($sformatf("rand%0d_valid", i), out_valid, 1);
            check($sformatf("rand%0d_res_op%0h", i, OpSel), Res, exp);
        end
        in_valid = 1'b0;

        // Flush in cycle 10 of MULTU with HI=LO=0x1234
        run_md(OP_DIVU, 32'h12341234, 32'h00010000, 32'h1234, 32'h1234, "divu_pre");
        in_valid = 1'b1; OpSel = OP_MULTU; A = 32'd3; B = 32'd5;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_ready", in_ready, 1);
        check("flush_valid", out_valid, 0);
        check("flush_hi", hi, 32'h1234);
        check("flush_lo", lo, 32'h1234);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (out_valid) pulses++;
            end
            check("flush_no_pulse", pulses, 0);
        end
        check("flush_hi_late", hi, 32'h1234);

        // rst mid-DIVU
        in_valid = 1'b1; OpSel = OP_DIVU; A = 32'd100; B = 32'd7;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstdiv_ready", in_ready, 1);
        check("rstdiv_valid", out_valid, 0);
        check("rstdiv_res", Res, 0);
        check("rstdiv_zero", zero, 1);
        check("rstdiv_hi", hi, 0);
        check("rstdiv_lo", lo, 0);
        in_valid = 1'b1; OpSel = OP_ADD; A = 32'd1; B = 32'd2;
        tick();
        in_valid = 1'b0;
        check("post_rst_res", Res, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
